// File: rtl/vector_element_counter.sv
// rtl/vector_element_counter.sv - element index sequencer for one vector instruction
module vector_element_counter #(
  parameter int NUM_LANES = 2,
  parameter int VL_W      = 8
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 start,
  input  logic [VL_W-1:0]      vl,
  input  logic [VL_W-1:0]      vstart,
  input  logic                 stall,
  input  logic                 flush,
  output logic                 ready,
  output logic                 valid,
  output logic [VL_W-1:0]      offset,
  output logic [NUM_LANES-1:0] lane_active,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [VL_W:0] LANES_EXT = (VL_W+1)'(NUM_LANES);

  state_t          state_q, state_d;
  logic [VL_W-1:0] offset_q, offset_d;
  logic [VL_W-1:0] vl_q, vl_d;
  logic            done_q, done_d;

  logic            run;
  logic            last;
  logic            accept;
  logic [VL_W:0]   next_off_ext;

  // Group advance and end-of-vector test, one bit wider so offset+lanes never wraps.
  always_comb begin
    run          = (state_q == RUN);
    next_off_ext = {1'b0, offset_q} + LANES_EXT;
    last         = run && (next_off_ext >= {1'b0, vl_q});
  end

  // Next-state and outputs; flush overrides every other event.
  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    vl_d     = vl_q;
    done_d   = 1'b0;

    ready  = !run || (last && !stall);
    valid  = run;
    busy   = run;
    offset = offset_q;
    done   = !flush && (done_q || (last && !stall));
    accept = start && ready && !flush;

    if (flush) begin
      state_d  = IDLE;
      offset_d = '0;
    end else if (accept) begin
      if (vstart < vl) begin
        state_d  = RUN;
        vl_d     = vl;
        offset_d = vstart;
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end else if (run && !stall) begin
      if (last) begin
        state_d = IDLE;
      end else begin
        offset_d = next_off_ext[VL_W-1:0];
      end
    end
  end

  // Per-lane enables; the final group may be partial.
  always_comb begin
    lane_active = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_active[i] = run && (({1'b0, offset_q} + (VL_W+1)'(i)) < {1'b0, vl_q});
    end
  end

  // State, offset, captured vl and pending empty-instruction done.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      offset_q <= '0;
      vl_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      vl_q     <= vl_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_vector_element_counter.sv
// tb/tb_vector_element_counter.sv - table-driven bench for vector_element_counter
module tb_vector_element_counter;

  logic       CLK;
  logic       nRST;
  logic       start;
  logic [7:0] vl;
  logic [7:0] vstart;
  logic       stall;
  logic       flush;
  logic       ready;
  logic       valid;
  logic [7:0] offset;
  logic [1:0] lane_active;
  logic       busy;
  logic       done;

  int checks;
  int failures;

  vector_element_counter #(.NUM_LANES(2), .VL_W(8)) dut (
    .CLK(CLK), .nRST(nRST), .start(start), .vl(vl), .vstart(vstart),
    .stall(stall), .flush(flush), .ready(ready), .valid(valid),
    .offset(offset), .lane_active(lane_active), .busy(busy), .done(done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       start;
    logic [7:0] vl;
    logic [7:0] vstart;
    logic       stall;
    logic       flush;
    logic       e_ready;
    logic       e_valid;
    logic [7:0] e_offset;
    logic [1:0] e_lane;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  vec_t rows[$];

  function automatic vec_t mk(logic s, int v, int vs, logic st, logic fl,
                              logic r, logic va, int off, logic [1:0] ln,
                              logic b, logic d);
    vec_t t;
    t.start = s; t.vl = 8'(v); t.vstart = 8'(vs); t.stall = st; t.flush = fl;
    t.e_ready = r; t.e_valid = va; t.e_offset = 8'(off); t.e_lane = ln;
    t.e_busy = b; t.e_done = d;
    return t;
  endfunction

  task automatic check(string name, int idx, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%0d expected=%0d", name, idx, act, exp);
    end
  endtask

  task automatic check_outputs(int idx, vec_t t);
    check("ready", idx, int'(ready), int'(t.e_ready));
    check("valid", idx, int'(valid), int'(t.e_valid));
    check("lane_active", idx, int'(lane_active), int'(t.e_lane));
    check("busy", idx, int'(busy), int'(t.e_busy));
    check("done", idx, int'(done), int'(t.e_done));
    if (t.e_valid) check("offset", idx, int'(offset), int'(t.e_offset));
  endtask

  initial begin
    checks = 0; failures = 0;
    nRST = 1'b0; start = 0; vl = 0; vstart = 0; stall = 0; flush = 0;

    //          st vl vs stl fl  rdy val off lane   busy done
    // vl=5 vstart=0
    rows.push_back(mk(1, 5, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 2'b11, 1, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 1, 2, 2'b11, 1, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 1, 1, 4, 2'b01, 1, 1));
    rows.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0));
    // vl=4 vstart=1 (unaligned)
    rows.push_back(mk(1, 4, 1, 0, 0, 1, 0, 0, 2'b00, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 2'b11, 1, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 1, 1, 3, 2'b01, 1, 1));
    rows.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0));
    // vl=6 with stall in N+2..N+3
    rows.push_back(mk(1, 6, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 2'b11, 1, 0));
    rows.push_back(mk(0, 0, 0, 1, 0, 0, 1, 2, 2'b11, 1, 0));
    rows.push_back(mk(0, 0, 0, 1, 0, 0, 1, 2, 2'b11, 1, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 1, 2, 2'b11, 1, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 1, 1, 4, 2'b11, 1, 1));
    rows.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0));
    // empty: vl=0, then vl=3 vstart=3
    rows.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 1));
    rows.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0));
    rows.push_back(mk(1, 3, 3, 0, 0, 1, 0, 0, 2'b00, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 1));
    rows.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0));
    // back-to-back: vl=2 then vl=4 started in the done cycle
    rows.push_back(mk(1, 2, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0));
    rows.push_back(mk(1, 4, 0, 0, 0, 1, 1, 0, 2'b11, 1, 1));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 2'b11, 1, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 1, 1, 2, 2'b11, 1, 1));
    rows.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0));
    // flush at offset 2 of vl=8 with simultaneous start (dropped)
    rows.push_back(mk(1, 8, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 2'b11, 1, 0));
    rows.push_back(mk(1, 3, 0, 0, 1, 0, 1, 2, 2'b11, 1, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0));
    // flush cancels a pending empty-instruction done
    rows.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0));
    // flush on the last group suppresses done and drops start
    rows.push_back(mk(1, 2, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0));
    rows.push_back(mk(1, 6, 0, 0, 1, 1, 1, 0, 2'b11, 1, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0));
    // stall on the last group holds done and ready low
    rows.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0));
    rows.push_back(mk(1, 4, 0, 1, 0, 0, 1, 0, 2'b01, 1, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 2'b01, 1, 1));
    rows.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0));

    // Reset state
    #2;
    check("rst_ready", -1, int'(ready), 1);
    check("rst_valid", -1, int'(valid), 0);
    check("rst_offset", -1, int'(offset), 0);
    check("rst_lane", -1, int'(lane_active), 0);
    check("rst_busy", -1, int'(busy), 0);
    check("rst_done", -1, int'(done), 0);
    @(negedge CLK);
    nRST = 1'b1;

    foreach (rows[k]) begin
      @(posedge CLK);
      #1;
      start = rows[k].start; vl = rows[k].vl; vstart = rows[k].vstart;
      stall = rows[k].stall; flush = rows[k].flush;
      @(negedge CLK);
      check_outputs(k, rows[k]);
    end

    // Async reset mid-RUN: start vl=8, run two groups, drop nRST between edges
    @(posedge CLK); #1;
    start = 1; vl = 8; vstart = 0; stall = 0; flush = 0;
    @(posedge CLK); #1;
    start = 0;
    @(posedge CLK); #1;
    check("pre_rst_valid", 100, int'(valid), 1);
    check("pre_rst_offset", 100, int'(offset), 2);
    #2;
    nRST = 1'b0;
    #1;
    check("arst_valid", 101, int'(valid), 0);
    check("arst_busy", 101, int'(busy), 0);
    check("arst_offset", 101, int'(offset), 0);
    check("arst_lane", 101, int'(lane_active), 0);
    check("arst_done", 101, int'(done), 0);
    check("arst_ready", 101, int'(ready), 1);
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    check("post_rst_done", 102, int'(done), 0);
    check("post_rst_valid", 102, int'(valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
